// File: rtl/digit_entry_pkg.sv
// Shared constants and state encoding for the keypad digit-entry buffer.
package digit_entry_pkg;

    localparam int KEY_BKSP      = 10;
    localparam int KEY_ENTER     = 11;
    localparam int KEY_CLR       = 12;
    localparam int DEFAULT_BLANK = 16;
    localparam int DEFAULT_ERRC  = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CONV,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step used by the decimal-to-binary conversion.
module bcd_mac10 #(
    parameter int VW = 10
) (
    input  logic [VW-1:0] i_in,
    input  logic [3:0]    i_d,
    output logic [VW-1:0] o_out
);

    // x*10 = x*8 + x*2, keeps the step a pair of shifts and adds
    assign o_out = (i_in << 3) + (i_in << 1) + VW'(i_d);

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit accumulator: shifting display buffer with backspace/clear, then a
// serial most-significant-first decimal-to-binary conversion with range check on enter.
module digit_entry_buffer
    import digit_entry_pkg::*;
#(
    parameter int NDIG   = 3,
    parameter int DW     = 5,
    parameter int VW     = 10,
    parameter int MAXVAL = 255,
    parameter int BLANK  = DEFAULT_BLANK,
    parameter int ERRC   = DEFAULT_ERRC
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_key_valid,
    input  logic [DW-1:0]                i_key_code,
    output logic                         o_key_ready,
    output logic [NDIG*DW-1:0]           o_dig,
    output logic [$clog2(NDIG+1)-1:0]    o_count,
    output logic [VW-1:0]                o_value,
    output logic                         o_value_valid,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int CW = $clog2(NDIG + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [DW-1:0] C_BKSP  = DW'(KEY_BKSP);
    localparam logic [DW-1:0] C_ENTER = DW'(KEY_ENTER);
    localparam logic [DW-1:0] C_CLR   = DW'(KEY_CLR);
    localparam logic [DW-1:0] C_BLANK = DW'(BLANK);
    localparam logic [DW-1:0] C_ERRC  = DW'(ERRC);

    state_t                     r_state;
    logic [NDIG-1:0][DW-1:0]    r_dig;
    logic [CW-1:0]              r_count;
    logic [VW-1:0]              r_value;
    logic                       r_value_valid;
    logic                       r_err;
    logic [VW-1:0]              r_acc;
    logic [IW-1:0]              r_idx;

    logic [NDIG-1:0][DW-1:0]    w_blankDig;
    logic [NDIG-1:0][DW-1:0]    w_errDig;
    logic [VW-1:0]              w_macOut;
    logic                       w_isDigit;

    assign w_blankDig = {NDIG{C_BLANK}};
    assign w_errDig   = {NDIG{C_ERRC}};
    assign w_isDigit  = (i_key_code < DW'(10));

    bcd_mac10 #(.VW(VW)) u_mac (
        .i_in  (r_acc),
        .i_d   (r_dig[r_idx][3:0]),
        .o_out (w_macOut)
    );

    // Keys are only looked at outside CONV, so strobes during a conversion are simply lost
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_dig         <= w_blankDig;
            r_count       <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_err         <= 1'b0;
            r_acc         <= '0;
            r_idx         <= '0;
        end else begin
            r_value_valid <= 1'b0;
            if (r_state == S_CONV) begin
                r_acc <= w_macOut;
                r_idx <= r_idx - IW'(1);
                if (r_idx == '0) begin
                    if (w_macOut > VW'(MAXVAL)) begin
                        r_dig   <= w_errDig;
                        r_err   <= 1'b1;
                        r_state <= S_ERROR;
                    end else begin
                        r_value       <= w_macOut;
                        r_value_valid <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
            end else if (i_key_valid) begin
                if (i_key_code == C_CLR) begin
                    r_dig   <= w_blankDig;
                    r_count <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end else if (w_isDigit) begin
                    if (r_state == S_DONE) begin
                        r_dig      <= w_blankDig;
                        r_dig[0]   <= i_key_code;
                        r_count    <= CW'(1);
                        r_state    <= S_ENTRY;
                    end else if ((r_state == S_IDLE || r_state == S_ENTRY) &&
                                 (r_count < CW'(NDIG))) begin
                        r_dig   <= {r_dig[NDIG-2:0], i_key_code};
                        r_count <= r_count + CW'(1);
                        r_state <= S_ENTRY;
                    end
                end else if (i_key_code == C_BKSP && r_state == S_ENTRY) begin
                    r_dig   <= {C_BLANK, r_dig[NDIG-1:1]};
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= S_IDLE;
                    end
                end else if (i_key_code == C_ENTER && r_state == S_ENTRY) begin
                    r_acc   <= '0;
                    r_idx   <= IW'(r_count - CW'(1));
                    r_state <= S_CONV;
                end
            end
        end
    end

    assign o_dig         = r_dig;
    assign o_count       = r_count;
    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;
    assign o_err         = r_err;
    assign o_busy        = (r_state == S_CONV);
    assign o_key_ready   = (r_state != S_CONV);

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Self-checking bench: directed scenarios plus random key streams against a queue-based model.
module tb_digit_entry_buffer;

    localparam int NDIG   = 3;
    localparam int DW     = 5;
    localparam int VW     = 10;
    localparam int MAXVAL = 255;
    localparam int BLANK  = 16;
    localparam int ERRC   = 17;
    localparam int CW     = $clog2(NDIG + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                keyValid;
    logic [DW-1:0]       keyCode;
    logic                keyReady;
    logic [NDIG*DW-1:0]  dig;
    logic [CW-1:0]       count;
    logic [VW-1:0]       value;
    logic                valueValid;
    logic                busy;
    logic                err;

    logic                k4Valid;
    logic [DW-1:0]       k4Code;
    logic                k4Ready;
    logic [4*DW-1:0]     dig4;
    logic [2:0]          count4;
    logic [13:0]         value4;
    logic                valueValid4;
    logic                busy4;
    logic                err4;

    int total = 0;
    int bad   = 0;

    int q[$];
    bit mErr;
    bit mDone;
    int mValue;

    always #5 clk = ~clk;

    digit_entry_buffer #(
        .NDIG(NDIG), .DW(DW), .VW(VW), .MAXVAL(MAXVAL), .BLANK(BLANK), .ERRC(ERRC)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_key_valid(keyValid), .i_key_code(keyCode),
        .o_key_ready(keyReady), .o_dig(dig), .o_count(count), .o_value(value),
        .o_value_valid(valueValid), .o_busy(busy), .o_err(err)
    );

    digit_entry_buffer #(
        .NDIG(4), .DW(DW), .VW(14), .MAXVAL(9999), .BLANK(BLANK), .ERRC(ERRC)
    ) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_key_valid(k4Valid), .i_key_code(k4Code),
        .o_key_ready(k4Ready), .o_dig(dig4), .o_count(count4), .o_value(value4),
        .o_value_valid(valueValid4), .o_busy(busy4), .o_err(err4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NDIG*DW-1:0] expDig();
        logic [NDIG*DW-1:0] v;
        int f;
        for (int i = 0; i < NDIG; i++) begin
            if (mErr)              f = ERRC;
            else if (i < q.size()) f = q[q.size()-1-i];
            else                   f = BLANK;
            v[i*DW +: DW] = DW'(f);
        end
        return v;
    endfunction

    task automatic modelReset();
        q.delete();
        mErr   = 1'b0;
        mDone  = 1'b0;
        mValue = 0;
    endtask

    // Non-enter key effects, written from the user-visible rules
    task automatic modelKey(input int code);
        if (code == 12) begin
            q.delete();
            mErr  = 1'b0;
            mDone = 1'b0;
        end else if (mErr) begin
        end else if (code < 10) begin
            if (mDone) begin
                q.delete();
                q.push_back(code);
                mDone = 1'b0;
            end else if (q.size() < NDIG) begin
                q.push_back(code);
            end
        end else if (code == 10 && !mDone && q.size() > 0) begin
            void'(q.pop_back());
        end
    endtask

    task automatic checkOutput(input string tag, input bit expValid);
        check({tag, ".dig"},   dig, expDig());
        check({tag, ".count"}, count, q.size());
        check({tag, ".value"}, value, mValue);
        check({tag, ".err"},   err, mErr);
        check({tag, ".vv"},    valueValid, expValid);
        check({tag, ".busy"},  busy, 1'b0);
        check({tag, ".ready"}, keyReady, 1'b1);
    endtask

    task automatic runConversion(input int n, input int acc, input bit noise);
        int busyCycles = 0;
        int pulses     = 0;
        int cyc        = 0;
        while (busy === 1'b1 && cyc < NDIG + 4) begin
            busyCycles++;
            if (valueValid === 1'b1 || keyReady !== 1'b0) pulses++;
            if (noise) begin
                keyValid = 1'b1;
                keyCode  = DW'($urandom_range(0, 15));
            end
            @(negedge clk);
            keyValid = 1'b0;
            cyc++;
        end
        keyValid = 1'b0;
        if (acc > MAXVAL) mErr = 1'b1;
        else              mValue = acc;
        mDone = (acc <= MAXVAL);
        check("conv.busyCycles", busyCycles, n);
        check("conv.earlyPulseOrReady", pulses, 0);
        checkOutput("conv.result", acc <= MAXVAL);
        @(negedge clk);
        check("conv.pulseWidth", valueValid, 1'b0);
    endtask

    task automatic applyStimulus(input int code, input bit noise);
        int  n;
        int  acc;
        bit  conv;
        conv = (code == 11) && !mErr && !mDone && q.size() > 0;
        n    = q.size();
        acc  = 0;
        foreach (q[i]) acc = acc * 10 + q[i];
        @(negedge clk);
        keyValid = 1'b1;
        keyCode  = DW'(code);
        @(negedge clk);
        keyValid = 1'b0;
        if (conv) begin
            runConversion(n, acc, noise);
        end else begin
            modelKey(code);
            checkOutput($sformatf("key%0d", code), 1'b0);
        end
    endtask

    task automatic press4(input int code);
        @(negedge clk);
        k4Valid = 1'b1;
        k4Code  = DW'(code);
        @(negedge clk);
        k4Valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int busyCycles;
        int pulses;
        keyValid = 1'b0;
        keyCode  = '0;
        k4Valid  = 1'b0;
        k4Code   = '0;
        rst      = 1'b1;
        modelReset();
        #1;
        checkOutput("reset", 1'b0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Scenario: 128 accepted, then a new digit starts fresh
        applyStimulus(1, 0); applyStimulus(2, 0); applyStimulus(8, 0);
        applyStimulus(11, 0);
        applyStimulus(7, 0);
        applyStimulus(12, 0);

        // Scenario: 256 out of range, error sticks until clear
        applyStimulus(2, 0); applyStimulus(5, 0); applyStimulus(6, 0);
        applyStimulus(11, 0);
        applyStimulus(3, 0);
        applyStimulus(10, 0);
        applyStimulus(11, 0);
        applyStimulus(12, 0);

        // Scenario: overflow digit ignored, backspace, 45
        applyStimulus(4, 0); applyStimulus(5, 0); applyStimulus(6, 0);
        applyStimulus(7, 0);
        applyStimulus(10, 0);
        applyStimulus(11, 0);
        applyStimulus(12, 0);

        // Scenario: empty-buffer keys, unused codes, noise during conversion
        applyStimulus(10, 0);
        applyStimulus(11, 0);
        applyStimulus(13, 0);
        applyStimulus(9, 0); applyStimulus(9, 0);
        applyStimulus(11, 1);

        // Async reset mid-run and mid-conversion
        applyStimulus(1, 0); applyStimulus(9, 0);
        @(negedge clk);
        keyValid = 1'b1;
        keyCode  = DW'(11);
        @(negedge clk);
        keyValid = 1'b0;
        check("preReset.busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midConvReset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valueValid !== 1'b0) pulses++;
        end
        check("postReset.noPulse", pulses, 0);
        checkOutput("postReset", 1'b0);

        // Random key streams
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        // Four-digit variant: 9999 fits exactly
        press4(9); press4(9); press4(9); press4(9);
        press4(11);
        busyCycles = 0;
        cyc        = 0;
        while (busy4 === 1'b1 && cyc < 10) begin
            busyCycles++;
            @(negedge clk);
            cyc++;
        end
        check("ndig4.busyCycles", busyCycles, 4);
        check("ndig4.vv", valueValid4, 1'b1);
        check("ndig4.value", value4, 9999);
        check("ndig4.err", err4, 1'b0);
        check("ndig4.dig", dig4, {4{5'd9}});
        check("ndig4.count", count4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_entry_buffer.md
Name: digit_entry_buffer

Overview:
- Parametrised keypad digit accumulator for the RGB colour-entry path. Collects up to NDIG decimal digits from the keypad decoder as a shifting display buffer, with backspace, clear and enter.
- On enter, converts the digits sequentially to binary and range-checks the result against MAXVAL. Publishes the value with a one-cycle strobe, or shows the error pattern on the display.
- Sits between the keypad decoder and the RGB channel registers/7-segment driver.

Parameters:
- NDIG, 3: number of digit positions.
- DW, 5: width of a digit/display code.
- VW, 10: binary value width; must satisfy 2^VW > 10^NDIG - 1.
- MAXVAL, 255: largest accepted value; larger values raise an error.
- BLANK, 16: display code for an empty position.
- ERRC, 17: display code shown in the error state.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- key_valid  in  1  one-cycle strobe; key_code is sampled when key_valid && key_ready.
- key_code  in  DW  0-9 digit; 10 backspace; 11 enter; 12 clear; 13..2^DW-1 ignored.
- key_ready  out  1  high when keys are accepted; low while busy.
- dig  out  NDIG*DW  display digits; bits [DW-1:0] = units, next field = tens, and so on.
- count  out  clog2(NDIG+1)  number of digits entered.
- value  out  VW  last valid converted value.
- value_valid  out  1  one-cycle pulse when value is updated.
- busy  out  1  conversion in progress.
- err  out  1  out-of-range result latched.

Behaviour:
- Reset (async, any state, including mid-conversion):
  - All dig fields = BLANK; count=0, value=0.
  - value_valid=0, busy=0, err=0.
  - State IDLE; any conversion in progress is aborted.
- States: IDLE, ENTRY, CONV, DONE, ERROR. key_ready = !busy = (state != CONV). Keys arriving while key_ready=0 are dropped, not queued.
- Digit key (IDLE/ENTRY):
  - If count<NDIG: shift digits up one position, new digit into units, count+1, state ENTRY.
  - If count==NDIG: ignored; no wrap, no change.
- Backspace (ENTRY):
  - Shift digits down one position, top position = BLANK, count-1. If count becomes 0, state IDLE.
  - Ignored in IDLE.
- Clear (any state except CONV): all fields BLANK, count=0, err=0, state IDLE. value is retained.
- Enter:
  - Ignored when count==0.
  - Otherwise: state CONV, acc=0, idx=count-1.
- CONV:
  - Each edge: acc <= acc*10 + dig[idx], idx-1. Processes exactly count digits, most significant first.
  - On the last step (idx==0) the new acc is compared with MAXVAL:
    - acc <= MAXVAL: value <= acc, value_valid=1 for one cycle, state DONE. Display keeps the entered digits.
    - acc > MAXVAL: all fields = ERRC, err=1, value unchanged, no strobe, state ERROR.
- Latency: value_valid is high in the cycle after the count-th clock edge following the edge that accepted enter (1..NDIG cycles).
- acc is VW bits wide; intermediate results never exceed 10^NDIG-1, so there is no overflow.
- DONE:
  - A digit key starts a fresh entry: buffer blanked, digit placed in units, count=1, state ENTRY.
  - Backspace and enter are ignored.
- ERROR: only clear exits; digit, backspace and enter keys are ignored.
- Unused key codes (13 and above) have no effect in any state.

Decomposition:
- Shared package (digit_entry_pkg): key-code constants KEY_BKSP=10, KEY_ENTER=11, KEY_CLR=12; BLANK/ERRC codes; state enum.
- One sub-module, bcd_mac10: combinational out = in*10 + d, with a VW-bit in and a 4-bit d. Instantiated once in the CONV datapath.

Test Plan:
1. Assert rst -> dig = {16,16,16}, count=0, value=0, key_ready=1. Assert rst again mid-run -> same values immediately, without waiting for a clock edge.
2. Keys 1,2,8, then enter -> dig = {1,2,8}. busy high for 3 cycles, then value=128 with a single value_valid pulse. Next, digit 7 -> dig = {16,16,7}, count=1.
3. Keys 2,5,6, then enter -> after 3 cycles err=1, dig = {17,17,17}, value unchanged, no value_valid. Digit key -> no change. Clear -> blanks, err=0.
4. Keys 4,5,6,7 -> the 7 is ignored, dig = {4,5,6}. Backspace -> {16,4,5}, count=2. Enter -> value=45 after 2 cycles.
5. Backspace and enter at count=0 -> no change. Key strobes during CONV -> dropped (key_ready=0), result unaffected. rst during CONV -> IDLE, no value_valid.
6. NDIG=4, VW=14, MAXVAL=9999: keys 9,9,9,9, enter -> value=9999 after 4 cycles, no error.
